mmio_fifo_drainer: RTL and testbench

- Bus master that drains a memory-mapped FIFO slave over its 4-bit register port and re-emits the words as a valid/ready stream.
- Placed directly downstream of the memory-mapped FIFO. Periodically polls the COUNT register, then pops up to MAX_BURST words through the DATA register.
- Can issue a FLUSH write to the CONTROL register on request.

---
 rtl/mmio_fifo_drainer_pkg.sv | 22 ++
 rtl/mmio_drain_outbuf.sv | 65 ++++++
 rtl/mmio_fifo_drainer.sv | 185 ++++++++++++++++++
 tb/tb_mmio_fifo_drainer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_fifo_drainer_pkg.sv
// Shared constants for the MMIO FIFO drainer: the slave register map,
// the flush bit position and the drainer state encoding.
package mmio_fifo_drainer_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;
  localparam logic [3:0] REG_COUNT  = 4'hC;

  localparam int unsigned CTRL_FLUSH_BIT = 1;

  typedef enum logic [2:0] {
    IDLE,
    POLL_REQ,
    POLL_WAIT,
    DATA_REQ,
    DATA_WAIT,
    FLUSH_REQ,
    FLUSH_WAIT
  } drain_state_e;

endpackage

// File: rtl/mmio_drain_outbuf.sv
// Two-entry in-order valid/ready output buffer for the drainer.
// The head entry drives the stream, so out_data holds while stalled.
// The caller never pushes when free_slots is 0.
module mmio_drain_outbuf #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [1:0]            free_slots,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [1:0]            cnt_q;
  logic                  pop;

  assign out_valid  = (cnt_q != 2'd0);
  assign out_data   = head_q;
  assign free_slots = 2'd2 - cnt_q;
  assign pop        = out_valid && out_ready;

  // Occupancy and entry update for every push/pop combination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            head_q <= push_data;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && push) begin
            head_q <= push_data;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end else if (push) begin
            tail_q <= push_data;
            cnt_q  <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= push_data;
            end else begin
              cnt_q <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mmio_fifo_drainer.sv
// Bus master that polls an MMIO FIFO's COUNT register, pops up to
// MAX_BURST words through DATA and re-emits them as a valid/ready stream.
// Optional MMIO_DRAIN_STATS_EN builds the drain_count push counter;
// without it drain_count is tied to 0.
module mmio_fifo_drainer
  import mmio_fifo_drainer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned COUNT_WIDTH   = 5,
  parameter int unsigned MAX_BURST     = 8,
  parameter int unsigned POLL_INTERVAL = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush_req,
  output logic                  m_valid,
  output logic                  m_write,
  output logic [3:0]            m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic [31:0]           drain_count
);

  localparam int unsigned BL_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TM_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  drain_state_e          state_q, state_d;
  logic [BL_W-1:0]       burst_q, burst_d;
  logic [BL_W-1:0]       burst_init;
  logic [TM_W-1:0]       timer_q;
  logic                  flush_pend_q;
  logic                  flush_pend;
  logic [COUNT_WIDTH-1:0] poll_n;
  logic                  push;
  logic [1:0]            free_slots;

  assign poll_n     = m_rdata[COUNT_WIDTH-1:0];
  assign burst_init = (32'(poll_n) > MAX_BURST) ? BL_W'(MAX_BURST) : BL_W'(poll_n);
  assign flush_pend = flush_pend_q || flush_req;
  assign busy       = (state_q != IDLE);

  // State, burst counter and pending-flush registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      flush_pend_q <= flush_pend && (state_q != FLUSH_REQ);
    end
  end

  // Poll interval timer: runs only while idle and enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (state_q != IDLE || !enable || state_d != IDLE) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TM_W'(1);
    end
  end

  // Next-state decode and bus request generation.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    m_valid = 1'b0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_pend) begin
          state_d = FLUSH_REQ;
        end else if (enable && timer_q == TM_W'(POLL_INTERVAL - 1)) begin
          state_d = POLL_REQ;
        end
      end
      POLL_REQ: begin
        if (flush_pend) begin
          state_d = FLUSH_REQ;
        end else if (!enable) begin
          state_d = IDLE;
          burst_d = '0;
        end else begin
          m_valid = 1'b1;
          m_addr  = REG_COUNT;
          state_d = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (m_ready) begin
          if (poll_n == '0 || !enable) begin
            state_d = IDLE;
            burst_d = '0;
          end else begin
            state_d = DATA_REQ;
            burst_d = burst_init;
          end
        end
      end
      DATA_REQ: begin
        // Nothing is in flight here, so one free slot covers the word requested now.
        if (flush_pend) begin
          state_d = FLUSH_REQ;
        end else if (!enable) begin
          state_d = IDLE;
          burst_d = '0;
        end else if (free_slots != 2'd0) begin
          m_valid = 1'b1;
          m_addr  = REG_DATA;
          state_d = DATA_WAIT;
        end
      end
      DATA_WAIT: begin
        if (m_ready) begin
          push    = 1'b1;
          burst_d = burst_q - BL_W'(1);
          if (!enable) begin
            state_d = IDLE;
            burst_d = '0;
          end else if (burst_q == BL_W'(1)) begin
            state_d = POLL_REQ;
          end else begin
            state_d = DATA_REQ;
          end
        end
      end
      FLUSH_REQ: begin
        m_valid                 = 1'b1;
        m_write                 = 1'b1;
        m_addr                  = REG_CTRL;
        m_wdata[CTRL_FLUSH_BIT] = 1'b1;
        state_d                 = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (m_ready) begin
          state_d = IDLE;
          burst_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  mmio_drain_outbuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (m_rdata),
    .free_slots(free_slots),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

`ifdef MMIO_DRAIN_STATS_EN
  // Count every word accepted into the output buffer; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_count <= '0;
    end else if (push) begin
      drain_count <= drain_count + 32'd1;
    end
  end
`else
  assign drain_count = '0;
`endif

endmodule

// File: tb/tb_mmio_fifo_drainer.sv
// Directed self-checking bench for mmio_fifo_drainer with a small MMIO
// FIFO slave model, a bus transaction log and a stream capture.
module tb_mmio_fifo_drainer;

  localparam int unsigned LOG_DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flush_req;
  logic        m_valid;
  logic        m_write;
  logic [3:0]  m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [31:0] drain_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // slave model state
  logic [31:0] mem [64];
  int unsigned fill_n = 0;
  logic        fill_go = 1'b0;
  int unsigned head = 0;
  int unsigned tail = 0;
  logic        slv_ready = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        stale_ready = 1'b0;

  // bus log and stream capture
  logic [3:0]  lg_addr  [LOG_DEPTH];
  logic        lg_wr    [LOG_DEPTH];
  logic [31:0] lg_wdata [LOG_DEPTH];
  logic [31:0] lg_resp  [LOG_DEPTH];
  int unsigned lg_n = 0;
  logic [31:0] rx [256];
  int unsigned rx_n = 0;

  int unsigned lb, rb, pk, dcnt, vcnt;
  logic [31:0] polls [4];
  int unsigned bursts [4];

  assign m_ready = slv_ready | stale_ready;
  assign m_rdata = stale_ready ? 32'hDEAD_BEEF : slv_rdata;

  always #5 clk = ~clk;

  mmio_fifo_drainer #(
    .DATA_WIDTH   (32),
    .COUNT_WIDTH  (5),
    .MAX_BURST    (8),
    .POLL_INTERVAL(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .flush_req  (flush_req),
    .m_valid    (m_valid),
    .m_write    (m_write),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .drain_count(drain_count)
  );

  // MMIO FIFO slave: answers one cycle after each request and logs it.
  always @(posedge clk) begin
    slv_ready <= 1'b0;
    slv_rdata <= '0;
    if (fill_go) begin
      head <= 0;
      tail <= fill_n;
    end else if (m_valid) begin
      slv_ready <= 1'b1;
      if (lg_n < LOG_DEPTH) begin
        lg_addr[lg_n]  <= m_addr;
        lg_wr[lg_n]    <= m_write;
        lg_wdata[lg_n] <= m_wdata;
        lg_resp[lg_n]  <= (!m_write && m_addr == 4'hC) ? (tail - head) : 32'd0;
      end
      lg_n <= lg_n + 1;
      if (m_write) begin
        if (m_addr == 4'h8 && m_wdata[1]) head <= tail;
      end else if (m_addr == 4'hC) begin
        slv_rdata <= tail - head;
      end else if (m_addr == 4'h0 && head != tail) begin
        slv_rdata <= mem[head];
        head <= head + 1;
      end
    end
  end

  // Stream sink capture.
  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      if (rx_n < 256) rx[rx_n] <= out_data;
      rx_n <= rx_n + 1;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    flush_req = 1'b0;
    out_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic load(input int unsigned n, input logic [31:0] v0);
    for (int unsigned i = 0; i < n; i++) mem[i] = v0 + i;
    fill_n = n;
    fill_go = 1'b1;
    tick(1);
    fill_go = 1'b0;
  endtask

  task automatic wait_log(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (lg_n < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(lg_n >= n), 64'd1);
  endtask

  task automatic wait_rx(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (rx_n < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(rx_n >= n), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    flush_req = 1'b0;
    out_ready = 1'b0;
    tick(2);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_write", 64'(m_write), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_wdata", 64'(m_wdata), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drain_count", 64'(drain_count), 64'd0);

    // A: three words A,B,C with exact cycle timing
    do_reset();
    load(3, 32'hA);
    lb = lg_n; rb = rx_n;
    out_ready = 1'b1;
    enable = 1'b1;
    tick(3);
    chk("A_no_early_poll", 64'(m_valid), 64'd0);
    chk("A_idle_busy", 64'(busy), 64'd0);
    tick(1);
    chk("A_poll_valid", 64'(m_valid), 64'd1);
    chk("A_poll_addr", 64'(m_addr), 64'hC);
    chk("A_poll_write", 64'(m_write), 64'd0);
    tick(1);
    chk("A_poll_wait_novalid", 64'(m_valid), 64'd0);
    tick(1);
    chk("A_data_req", 64'({m_valid, m_addr}), 64'h10);
    tick(1);
    chk("A_lat_t1", 64'(out_valid), 64'd0);
    tick(1);
    chk("A_lat_t2", 64'({out_valid, out_data}), 64'h1_0000_000A);
    tick(4);
    chk("A_repoll_now", 64'({m_valid, m_addr}), 64'h1C);
    tick(1);
    chk("A_repoll_busy", 64'(busy), 64'd1);
    tick(1);
    chk("A_back_idle", 64'(busy), 64'd0);
    enable = 1'b0;
    chk("A_rx_count", 64'(rx_n - rb), 64'd3);
    for (int unsigned i = 0; i < 3; i++) chk("A_word", 64'(rx[rb + i]), 64'(32'hA + i));
    chk("A_log_count", 64'(lg_n - lb), 64'd5);
    chk("A_log1", 64'(lg_addr[lb + 1]), 64'h0);
    chk("A_log4", 64'(lg_addr[lb + 4]), 64'hC);
    chk("A_poll0_resp", 64'(lg_resp[lb]), 64'd3);
    chk("A_poll1_resp", 64'(lg_resp[lb + 4]), 64'd0);

    // D: flush during the third word of an 8-word burst
    do_reset();
    load(8, 32'h300);
    lb = lg_n; rb = rx_n;
    out_ready = 1'b1;
    enable = 1'b1;
    tick(10);
    chk("D_w3_issue", 64'({m_valid, m_addr}), 64'h10);
    tick(1);
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    chk("D_w3_out", 64'({out_valid, out_data}), 64'h1_0000_0302);
    chk("D_no_4th_read", 64'(m_valid), 64'd0);
    tick(1);
    chk("D_flush_wr", 64'({m_valid, m_write, m_addr}), 64'h38);
    chk("D_flush_wdata", 64'(m_wdata), 64'h2);
    tick(2);
    chk("D_idle_after", 64'(busy), 64'd0);
    enable = 1'b0;
    tick(2);
    chk("D_rx_count", 64'(rx_n - rb), 64'd3);
    for (int unsigned i = 0; i < 3; i++) chk("D_word", 64'(rx[rb + i]), 64'(32'h300 + i));
    chk("D_log_wr", 64'({lg_wr[lb + 4], lg_addr[lb + 4], lg_wdata[lb + 4]}), 64'h18_0000_0002);

    // B: 20 words in bursts of 8,8,4
    do_reset();
    load(20, 32'h100);
    lb = lg_n; rb = rx_n;
    out_ready = 1'b1;
    enable = 1'b1;
    wait_log(lb + 24, 300, "B_log_timeout");
    tick(1);
    enable = 1'b0;
    tick(4);
    pk = 0; dcnt = 0;
    for (int unsigned i = lb; i < lb + 24; i++) begin
      if (lg_addr[i] == 4'hC) begin
        if (pk > 0 && pk <= 3) bursts[pk - 1] = dcnt;
        if (pk < 4) polls[pk] = lg_resp[i];
        pk++;
        dcnt = 0;
      end else begin
        dcnt++;
      end
    end
    chk("B_npolls", 64'(pk), 64'd4);
    chk("B_poll0", 64'(polls[0]), 64'd20);
    chk("B_poll1", 64'(polls[1]), 64'd12);
    chk("B_poll2", 64'(polls[2]), 64'd4);
    chk("B_poll3", 64'(polls[3]), 64'd0);
    chk("B_burst0", 64'(bursts[0]), 64'd8);
    chk("B_burst1", 64'(bursts[1]), 64'd8);
    chk("B_burst2", 64'(bursts[2]), 64'd4);
    chk("B_rx_count", 64'(rx_n - rb), 64'd20);
    for (int unsigned i = 0; i < 20; i++) chk("B_word", 64'(rx[rb + i]), 64'(32'h100 + i));
`ifdef MMIO_DRAIN_STATS_EN
    chk("B_drain_count", 64'(drain_count), 64'd20);
`else
    chk("B_drain_count_off", 64'(drain_count), 64'd0);
`endif

    // C: stalled stream limits reads to buffer depth
    do_reset();
    load(5, 32'h200);
    lb = lg_n; rb = rx_n;
    enable = 1'b1;
    tick(30);
    chk("C_reads_limited", 64'(lg_n - lb), 64'd3);
    chk("C_head_held", 64'({out_valid, out_data}), 64'h1_0000_0200);
    vcnt = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      tick(1);
      if (m_valid) vcnt++;
    end
    chk("C_m_valid_quiet", 64'(vcnt), 64'd0);
    chk("C_data_stable", 64'(out_data), 64'h200);
    out_ready = 1'b1;
    wait_rx(rb + 5, 80, "C_rx_timeout");
    enable = 1'b0;
    tick(4);
    chk("C_rx_count", 64'(rx_n - rb), 64'd5);
    for (int unsigned i = 0; i < 5; i++) chk("C_word", 64'(rx[rb + i]), 64'(32'h200 + i));

    // E: reset during DATA_WAIT, stale m_ready afterwards
    do_reset();
    load(3, 32'h400);
    rb = rx_n;
    out_ready = 1'b1;
    enable = 1'b1;
    tick(7);
    rst = 1'b1;
    #1;
    chk("E_rst_m_valid", 64'({m_valid, m_write, m_addr}), 64'd0);
    chk("E_rst_m_wdata", 64'(m_wdata), 64'd0);
    chk("E_rst_out", 64'({out_valid, out_data}), 64'd0);
    chk("E_rst_busy", 64'(busy), 64'd0);
    chk("E_rst_count", 64'(drain_count), 64'd0);
    tick(1);
    rst = 1'b0;
    enable = 1'b0;
    stale_ready = 1'b1;
    tick(1);
    stale_ready = 1'b0;
    chk("E_stale_no_push", 64'(out_valid), 64'd0);
    chk("E_stale_idle", 64'(busy), 64'd0);
    tick(3);
    chk("E_stale_no_rx", 64'(rx_n - rb), 64'd0);
    chk("E_stale_count", 64'(drain_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
